// File: rtl/fp_mul_seq_if.sv
// Start/busy/done handshake bundle for the sequential FP multiplier.
// master = requester (coprocessor control), slave = fp_mul_seq.
interface fp_mul_seq_if;
    logic        start;
    logic [31:0] num1;
    logic [31:0] num2;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        inexact;

    modport master (
        output start, num1, num2,
        input  busy, done, result, overflow, underflow, inexact
    );

    modport slave (
        input  start, num1, num2,
        output busy, done, result, overflow, underflow, inexact
    );
endinterface

// File: rtl/fp_mul_seq.sv
// Multi-cycle IEEE-754 single-precision multiplier: shift-add mantissa engine,
// truncating normalisation, fixed latency for every operand class.
module fp_mul_seq #(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input logic         clk,
    input logic         rst,
    fp_mul_seq_if.slave bus
);

    localparam int unsigned N_CYC = 24 / BITS_PER_CYCLE;
    localparam int unsigned PW    = 24 + BITS_PER_CYCLE;
    localparam int unsigned CW    = 5;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_e;

    state_e         state_q, state_d;
    logic           sign_q, sign_d;
    logic [7:0]     ea_q, ea_d;
    logic [7:0]     eb_q, eb_d;
    logic [23:0]    m1_q, m1_d;
    logic [23:0]    m2_q, m2_d;
    logic [47:0]    acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [31:0]    result_q, result_d;
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;
    logic           inx_q, inx_d;

    logic [CW-1:0]       shamt;
    logic [PW-1:0]       pp;
    logic                norm;
    logic [22:0]         mant;
    logic                disc_nz;
    logic signed [9:0]   exp_s;
    logic                a_nan, a_inf, a_zero;
    logic                b_nan, b_inf, b_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b0;
            ea_q     <= '0;
            eb_q     <= '0;
            m1_q     <= '0;
            m2_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            ea_q     <= ea_d;
            eb_q     <= eb_d;
            m1_q     <= m1_d;
            m2_q     <= m2_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inx_q    <= inx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        ea_d     = ea_q;
        eb_d     = eb_q;
        m1_d     = m1_q;
        m2_d     = m2_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inx_d    = inx_q;

        // One multiplier slice per cycle, weighted by its bit position in m2.
        shamt = CW'(cnt_q * CW'(BITS_PER_CYCLE));
        pp    = PW'(m1_q) * PW'(m2_q[shamt +: BITS_PER_CYCLE]);

        norm    = acc_q[47];
        mant    = norm ? acc_q[46:24] : acc_q[45:23];
        disc_nz = norm ? (|acc_q[23:0]) : (|acc_q[22:0]);
        exp_s   = 10'(ea_q) + 10'(eb_q) - 10'd127 + 10'(norm);

        // Raw fraction bits survive in m1/m2[22:0] for special-case decoding.
        a_nan  = (&ea_q) & (|m1_q[22:0]);
        a_inf  = (&ea_q) & ~(|m1_q[22:0]);
        a_zero = ~(|ea_q) & ~(|m1_q[22:0]);
        b_nan  = (&eb_q) & (|m2_q[22:0]);
        b_inf  = (&eb_q) & ~(|m2_q[22:0]);
        b_zero = ~(|eb_q) & ~(|m2_q[22:0]);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sign_d  = bus.num1[31] ^ bus.num2[31];
                    ea_d    = bus.num1[30:23];
                    eb_d    = bus.num2[30:23];
                    m1_d    = {|bus.num1[30:23], bus.num1[22:0]};
                    m2_d    = {|bus.num2[30:23], bus.num2[22:0]};
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                acc_d = acc_q + (48'(pp) << shamt);
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N_CYC - 1)) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
                inx_d = 1'b0;
                if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
                    result_d = 32'h7FC0_0000;
                end else if (a_inf || b_inf) begin
                    result_d = {sign_q, 8'hFF, 23'b0};
                end else if (a_zero || b_zero) begin
                    result_d = {sign_q, 31'b0};
                end else begin
                    inx_d = disc_nz;
                    if (exp_s >= 10'sd255) begin
                        result_d = {sign_q, 8'hFF, 23'b0};
                        ovf_d    = 1'b1;
                    end else if (exp_s <= 10'sd0) begin
                        result_d = {sign_q, 31'b0};
                        unf_d    = 1'b1;
                    end else begin
                        result_d = {sign_q, exp_s[7:0], mant};
                    end
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    assign bus.inexact   = inx_q;

endmodule
